// File: rtl/n64_poll_scheduler.sv
// N64 controller poll sequencer: issues periodic or on-demand polls, drives the bit-level
// send/receive datapath through a start/done handshake and publishes the latest button word.
module n64_poll_scheduler #(
  parameter int unsigned POLL_PERIOD    = 200000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  POLL_CMD       = 8'h01,
  parameter int unsigned RESP_BITS      = 32
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        poll_now_i,
  output logic        tx_start_o,
  output logic [7:0]  tx_cmd_o,
  input  logic        tx_done_i,
  output logic        rx_enable_o,
  input  logic        rx_bit_valid_i,
  input  logic        rx_bit_i,
  output logic [31:0] buttons_o,
  output logic        buttons_valid_o,
  output logic        busy_o,
  output logic        timeout_err_o,
  output logic [7:0]  err_count_o
);

  localparam int unsigned TimerW = $clog2(POLL_PERIOD);
  localparam int unsigned WdW    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(POLL_PERIOD - 1);
  localparam logic [WdW-1:0]    WdLast    = WdW'(TIMEOUT_CYCLES - 1);
  localparam logic [5:0]        CntLast   = 6'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StSend     = 3'd2,
    StWaitResp = 3'd3,
    StRecv     = 3'd4,
    StDone     = 3'd5,
    StFail     = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [WdW-1:0]     wd_q, wd_d;
  logic [5:0]         cnt_q, cnt_d;
  logic [31:0]        shift_q, shift_d;
  logic [31:0]        buttons_q, buttons_d;
  logic               pending_q, pending_d;
  logic               terr_q, terr_d;
  logic [7:0]         err_q, err_d;
  logic               tick;
  logic               go_start;
  logic [31:0]        shift_in;

  assign tick     = enable_i && (timer_q == TimerLast);
  assign shift_in = {shift_q[30:0], rx_bit_i};

  always_comb begin
    timer_d = (!enable_i || tick) ? '0 : timer_q + TimerW'(1);
  end

  always_comb begin
    state_d   = state_q;
    wd_d      = '0;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    terr_d    = terr_q;
    err_d     = err_q;
    go_start  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pending_q && enable_i) begin
          go_start = 1'b1;
          state_d  = StStart;
        end
      end
      StStart: begin
        shift_d = '0;
        cnt_d   = '0;
        state_d = StSend;
      end
      StSend: begin
        if (tx_done_i) begin
          cnt_d   = '0;
          state_d = StWaitResp;
        end else if (wd_q == WdLast) begin
          state_d = StFail;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StWaitResp, StRecv: begin
        if (rx_bit_valid_i) begin
          shift_d = shift_in;
          cnt_d   = cnt_q + 6'd1;
          if (cnt_q == CntLast) begin
            // Load on entry to DONE so buttons and its valid pulse appear together.
            buttons_d = shift_in;
            state_d   = StDone;
          end else begin
            state_d = StRecv;
          end
        end else if (wd_q == WdLast) begin
          state_d = StFail;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      StDone: begin
        terr_d  = 1'b0;
        state_d = StIdle;
      end
      StFail: begin
        terr_d = 1'b1;
        if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A new request in the START-transition cycle wins over the clear.
  always_comb begin
    pending_d = enable_i && (tick || poll_now_i || (pending_q && !go_start));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      wd_q      <= '0;
      cnt_q     <= '0;
      shift_q   <= '0;
      buttons_q <= '0;
      pending_q <= 1'b0;
      terr_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      wd_q      <= wd_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      pending_q <= pending_d;
      terr_q    <= terr_d;
      err_q     <= err_d;
    end
  end

  assign tx_start_o      = (state_q == StStart);
  assign tx_cmd_o        = POLL_CMD;
  assign rx_enable_o     = (state_q == StWaitResp) || (state_q == StRecv);
  assign buttons_o       = buttons_q;
  assign buttons_valid_o = (state_q == StDone);
  assign busy_o          = (state_q != StIdle);
  assign timeout_err_o   = terr_q;
  assign err_count_o     = err_q;

endmodule

// File: doc/n64_poll_scheduler.md
Name: n64_poll_scheduler

Overview:
- Sequences one complete N64 controller poll: command-byte transmit, turnaround, 32-bit status receive.
- Drives the bit-level N64 send/receive datapath through a start/done handshake and a per-bit receive strobe.
- Polls are issued on a free-running period or on demand.
- Publishes the latest button word with a one-cycle valid pulse, plus timeout/error status for the game logic.

Parameters:
- POLL_PERIOD, 200000: cycles between automatic polls; minimum 2.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles without progress; minimum 2.
- POLL_CMD, 8'h01: command byte sent to the controller.
- RESP_BITS, 32: response bits expected; range 1..32.

Ports:
- clk  in  1  system clock; single clock domain.
- Reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- enable  in  1  allows new polls to start.
- poll_now  in  1  one-cycle request for an immediate poll.
- tx_start  out  1  one-cycle pulse that starts a transmit on the datapath.
- tx_cmd  out  8  command byte; constant POLL_CMD.
- tx_done  in  1  datapath pulse after the command's stop bit is sent.
- rx_enable  out  1  enables the datapath receiver.
- rx_bit_valid  in  1  strobe: one decoded response bit is available.
- rx_bit  in  1  decoded bit value, qualified by rx_bit_valid.
- buttons  out  32  last good response, right-aligned, first bit received in the MSB position.
- buttons_valid  out  1  one-cycle pulse when buttons updates.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  sticky; set by a failed poll, cleared by the next good poll.
- err_count  out  8  saturating count of failed polls.

Behaviour:
- Reset (synchronous, priority over everything):
  - state=IDLE; period timer, watchdog, bit counter, shift register and poll_pending all cleared.
  - All outputs 0, except tx_cmd, which is always POLL_CMD.
  - Reset mid-transaction aborts at that edge; rx_enable and busy are low in the next cycle.
- Period timer:
  - Counts 0..POLL_PERIOD-1 while enable=1; at terminal count it wraps to 0 and sets poll_pending.
  - While enable=0, the timer is held at 0 and poll_pending is cleared.
- poll_now=1 with enable=1 sets poll_pending.
- poll_pending is single-depth; extra requests while pending merge.
- poll_pending is cleared on the START transition. If a new set arrives in the same cycle, set wins and pending stays 1.
- State machine, registered state, Moore outputs:
  - IDLE: if poll_pending && enable, go to START next cycle.
  - START: tx_start=1 for exactly this one cycle; clear the watchdog; go to SEND.
  - SEND: wait for tx_done, then go to WAIT_RESP. Clear the bit counter and watchdog on exit.
  - WAIT_RESP: rx_enable=1. The first rx_bit_valid shifts the bit in and goes to RECV, or straight to DONE if RESP_BITS=1.
  - RECV: rx_enable=1. Each rx_bit_valid shifts left (shift = {shift[30:0], rx_bit}) and increments the bit counter. The strobe that brings the count to RESP_BITS goes to DONE.
  - DONE: buttons <= shift register; buttons_valid=1 for this one cycle; timeout_err <= 0; go to IDLE.
  - FAIL: timeout_err <= 1; err_count increments, saturating at 255; buttons unchanged; go to IDLE.
- Watchdog:
  - Counts in SEND, WAIT_RESP and RECV.
  - Cleared on entry to each of those states and on every rx_bit_valid.
  - Reaching TIMEOUT_CYCLES-1 goes to FAIL next cycle.
  - If a progress event (tx_done or rx_bit_valid) arrives in that same cycle, progress wins and no FAIL occurs.
- Ignored events:
  - tx_done outside SEND.
  - rx_bit_valid outside WAIT_RESP/RECV, including the DONE cycle.
  - Extra bits after RESP_BITS are never captured.
- Deasserting enable mid-transaction does not abort; the poll completes through DONE or FAIL.
- Latency:
  - poll_pending seen in IDLE at cycle n gives tx_start at cycle n+1.
  - Final rx_bit_valid at cycle m gives buttons and buttons_valid at cycle m+1.
  - Back-to-back polls: from DONE, IDLE is entered the next cycle and START the cycle after, if pending.
- Unused state encodings recover to IDLE.

Test Plan (POLL_PERIOD=100, TIMEOUT_CYCLES=20, RESP_BITS=32):
1. Reset high for 3 cycles, then enable=1 → tx_start pulses once when the timer wraps (cycle 100 after enable) and again 100 cycles later; all outputs 0 during reset.
2. poll_now; model asserts tx_done after 10 cycles, then sends 32 bits of 32'hA5C3_0F81 (MSB first) spaced 4 cycles apart → buttons=32'hA5C3_0F81, buttons_valid high exactly one cycle (the cycle after the 32nd strobe), err_count=0.
3. Poll with the model sending only 12 bits, then silence → FAIL after 20 idle cycles: timeout_err=1, err_count=1, buttons unchanged. Next good poll clears timeout_err and leaves err_count=1.
4. Force 260 consecutive timeouts (tx_done never asserted) → err_count saturates at 255; busy low between polls.
5. Assert poll_now while busy, and have the period tick fire in the START cycle → exactly one further poll follows the current one; stray tx_done/rx_bit_valid in IDLE cause no state change.
6. Assert Reset mid-RECV at bit 17 → next cycle: state IDLE, rx_enable=0, busy=0. A subsequent full poll returns correct data with no residue from the aborted shift.
